viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Survivor-memory and traceback stage for the 4-state (K=3, rate-1/2) Viterbi decoder.
- Sits directly downstream of the four ACS units.
- Each trellis step it captures the four selected predecessor addresses and, on the frame's final step, the four path metrics.
- At frame end it traces back from the start state and emits the decoded bits in forward order through a valid/ready stream.

Parameters:
FRAME_LEN, 16, maximum trellis steps per frame (>=2); sets survivor memory depth and decoded-bit buffer size
CNT_W, 5, step counter/pointer width; must satisfy 2^CNT_W > FRAME_LEN

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  trellis step available
in_ready  output  1  block accepts a step (high only in FILL)
in_last  input  1  final step of frame, qualified by in_valid
in_addr  input  8  predecessor address per state; bits [2s+1:2s] belong to state s (s=0..3)
in_pm  input  28  7-bit path metric per state; bits [7s+6:7s] belong to state s
out_valid  output  1  decoded bit valid
out_ready  input  1  consumer accepts bit
out_bit  output  1  decoded bit
out_last  output  1  marks final decoded bit of frame
busy  output  1  high in TRACE or OUTPUT

Behaviour:
- Reset (async, rst=1):
  - FSM=FILL; counters=0.
  - in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
  - Memory contents undefined.
- FSM states: FILL, TRACE, OUTPUT.
- FILL:
  - Step accepted when in_valid&in_ready.
  - in_addr written to mem[wr_cnt]; wr_cnt increments.
  - Frame closes when in_last=1 or the accepted step is number FRAME_LEN (wr_cnt==FRAME_LEN-1), whichever comes first; both together is a single close.
  - On close: frame length n=wr_cnt+1; start state S sampled from in_pm of that same step; next state TRACE.
  - After a FRAME_LEN-step auto-close, steps are not accepted until the next FILL; in_last on the following step starts a new frame.
- Start state S (without macro):
  - Index of the minimum 7-bit unsigned metric in in_pm.
  - Ties go to the lowest index.
- TRACE:
  - One step per cycle: i runs n-1 down to 0, cur starts at S.
  - Each cycle: bits[i]=cur[1]; cur=mem[i][2*cur+1:2*cur].
  - Exactly n cycles, then OUTPUT.
  - in_ready=0, busy=1.
- OUTPUT:
  - out_valid=1, out_bit=bits[rd_cnt], out_last=(rd_cnt==n-1).
  - On out_valid&out_ready: rd_cnt++.
  - On the last bit transfer: FSM=FILL, counters cleared, out_valid=0, out_last=0.
  - Next frame accepted in the cycle after.
  - out_bit/out_last are held stable while out_valid=1 and out_ready=0.
- Latency:
  - Last-step acceptance edge at cycle t; TRACE occupies cycles t+1..t+n; out_valid first high at t+n+1.
  - Total out_valid-high cycles is at least n (exactly n with out_ready tied high).
- Decoded-bit rule: the decoded bit of a step is the MSB of the surviving state at that step (states 10, 11 decode to 1).
- Arithmetic: metric compare is unsigned 7-bit; no normalization is done here.
- Reset mid-frame in any state: frame discarded, outputs return to reset values immediately.
- in_valid high in TRACE/OUTPUT: ignored, no side effect.

Optional Feature:
- ZERO_TERM_EN defined: S is forced to state 00 (zero-tail-terminated frames); in_pm is ignored and the compare logic is omitted.
- ZERO_TERM_EN not defined: minimum-metric start state as above.

Test Plan:
- Frame n=4, in_last on step 3; mem programmed so state 11's survivor chain is 11<-10<-01<-10 (step0 addr for state 10 = 00); in_pm = {s3=2, s2=5, s1=6, s0=7} -> S=11; out_bit sequence 1,0,1,1; out_last on 4th; out_valid first high 5 cycles after last acceptance.
- Metric tie: in_pm all 7'd9 -> S=00; all-zero addresses -> 4 zero bits. With ZERO_TERM_EN, in_pm={s0=100, others=0} still gives S=00.
- 16 steps with in_last=0 -> auto-close at step 16, in_ready=0 from the next cycle, 16 bits out, out_last on the 16th.
- Backpressure: out_ready toggled 1,0,0,1,... -> each bit held stable while stalled; no bit lost or duplicated.
- in_last on the first step -> n=1: TRACE 1 cycle, single bit equal to S[1] with out_last=1.
- rst pulsed mid-TRACE, then a new 4-step frame -> outputs cleared asynchronously; new frame decodes correctly with no residue from the aborted frame.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback stage for a 4-state (K=3, rate-1/2) Viterbi
// decoder. It captures the predecessor addresses of each trellis step,
// traces back from the start state at frame end and streams the decoded bits
// out in forward order over a valid/ready handshake.
// Optional macro: ZERO_TERM_EN forces the traceback start state to 00 and
// removes the metric compare logic.
module viterbi_traceback #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [7:0]  in_addr,
  input  logic [27:0] in_pm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic        out_last,
  output logic        busy
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {FILL, TRACE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [7:0]           mem [FRAME_LEN];
  logic [FRAME_LEN-1:0] bits;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     last_idx;
  logic [CNT_W-1:0]     tr_idx;
  logic [CNT_W-1:0]     rd_cnt;
  logic [1:0]           cur;
  logic [1:0]           start_s;
  logic [1:0]           pred;
  logic [7:0]           row;
  logic                 accept;
  logic                 close;
  logic                 xfer;

  assign accept = (state == FILL) && in_valid;
  assign close  = accept && (in_last || (wr_cnt == CNT_W'(FRAME_LEN - 1)));
  assign xfer   = (state == OUTPUT) && out_ready;

`ifdef ZERO_TERM_EN
  // Zero-tail-terminated frames always end in state 00
  always_comb begin
    start_s = 2'b00;
  end
`else
  logic [6:0] pm0, pm1, pm2, pm3, lo_pm, hi_pm;
  logic [1:0] lo_idx, hi_idx;

  // Minimum-metric state; strict less-than keeps ties on the lower index
  always_comb begin
    pm0 = in_pm[6:0];
    pm1 = in_pm[13:7];
    pm2 = in_pm[20:14];
    pm3 = in_pm[27:21];
    lo_idx = (pm1 < pm0) ? 2'd1 : 2'd0;
    lo_pm  = (pm1 < pm0) ? pm1 : pm0;
    hi_idx = (pm3 < pm2) ? 2'd3 : 2'd2;
    hi_pm  = (pm3 < pm2) ? pm3 : pm2;
    start_s = (hi_pm < lo_pm) ? hi_idx : lo_idx;
  end
`endif

  // Predecessor of the current surviving state at step tr_idx
  always_comb begin
    row = mem[tr_idx[AW-1:0]];
    case (cur)
      2'd0:    pred = row[1:0];
      2'd1:    pred = row[3:2];
      2'd2:    pred = row[5:4];
      default: pred = row[7:6];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close) state_nxt = TRACE;
      TRACE:   if (tr_idx == '0) state_nxt = OUTPUT;
      OUTPUT:  if (xfer && (rd_cnt == last_idx)) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Stream outputs decoded from the registered state
  always_comb begin
    in_ready  = (state == FILL);
    busy      = (state == TRACE) || (state == OUTPUT);
    out_valid = (state == OUTPUT);
    out_bit   = 1'b0;
    out_last  = 1'b0;
    if (state == OUTPUT) begin
      out_bit  = bits[rd_cnt[AW-1:0]];
      out_last = (rd_cnt == last_idx);
    end
  end

  // Counters and traceback cursor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      last_idx <= '0;
      tr_idx   <= '0;
      rd_cnt   <= '0;
      cur      <= '0;
    end else begin
      case (state)
        FILL: begin
          if (close) begin
            wr_cnt   <= '0;
            last_idx <= wr_cnt;
            tr_idx   <= wr_cnt;
            cur      <= start_s;
          end else if (accept) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
          end
        end
        TRACE: begin
          cur    <= pred;
          tr_idx <= tr_idx - CNT_W'(1);
        end
        OUTPUT: begin
          if (xfer) begin
            if (rd_cnt == last_idx) rd_cnt <= '0;
            else                    rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Survivor and decoded-bit storage; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt[AW-1:0]] <= in_addr;
    if (state == TRACE) bits[tr_idx[AW-1:0]] <= cur[1];
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed self-checking bench for viterbi_traceback.
module tb_viterbi_traceback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [7:0]  in_addr = '0;
  logic [27:0] in_pm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_bit;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  viterbi_traceback #(.FRAME_LEN(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_addr(in_addr), .in_pm(in_pm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pm4(input int s3, input int s2, input int s1, input int s0);
    return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endfunction

  // Present one step for one clock edge (caller guarantees FILL)
  task automatic send_step(input logic [7:0] a, input logic [27:0] pm, input logic last);
    in_valid = 1'b1; in_addr = a; in_pm = pm; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Drain up to n bits with out_ready high, bounded in cycles
  task automatic collect(input int n, output logic [15:0] b, output logic [15:0] l, output int got);
    b = '0; l = '0; got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (out_valid) begin
        b[got] = out_bit; l[got] = out_last; got++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({out_bit, out_last, busy} !== 3'b000) begin bad++; $display("FAIL reset_bit_last_busy got=%b exp=000", {out_bit, out_last, busy}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] b, l; int got; int k;
    logic [3:0] exp_b;
`ifdef ZERO_TERM_EN
    exp_b = 4'b0000;
`else
    exp_b = 4'b1101;
`endif
    send_step(8'h00, pm4(0, 0, 0, 0), 1'b0);
    send_step(8'h08, pm4(0, 0, 0, 0), 1'b0);
    send_step(8'h10, pm4(0, 0, 0, 0), 1'b0);
    send_step(8'h80, pm4(2, 5, 6, 7), 1'b1);
    total++; if ({busy, in_ready, out_valid} !== 3'b100) begin bad++; $display("FAIL basic_trace_flags got=%b exp=100", {busy, in_ready, out_valid}); end
    // Stray steps while tracing must be ignored
    in_valid = 1'b1; in_last = 1'b1; in_addr = 8'hff; in_pm = '0;
    k = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = c; break; end
    end
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (k != 4) begin bad++; $display("FAIL basic_latency got=%0d edges exp=4", k); end
    collect(4, b, l, got);
    total++; if (got != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", got); end
    total++; if (b[3:0] !== exp_b) begin bad++; $display("FAIL basic_bits got=%b exp=%b", b[3:0], exp_b); end
    total++; if (l[3:0] !== 4'b1000) begin bad++; $display("FAIL basic_last got=%b exp=1000", l[3:0]); end
    total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++; $display("FAIL basic_back_to_fill got=%b exp=100", {in_ready, out_valid, busy}); end
  endtask

  task automatic test_tie();
    logic [15:0] b, l; int got;
    for (int i = 0; i < 3; i++) send_step(8'h00, pm4(9, 9, 9, 9), 1'b0);
    send_step(8'h00, pm4(9, 9, 9, 9), 1'b1);
    collect(4, b, l, got);
    total++; if (got != 4) begin bad++; $display("FAIL tie_count got=%0d exp=4", got); end
    total++; if (b[3:0] !== 4'b0000) begin bad++; $display("FAIL tie_bits got=%b exp=0000", b[3:0]); end
  endtask

  task automatic test_autoclose();
    logic [15:0] b, l, exp_b; int got;
`ifdef ZERO_TERM_EN
    exp_b = 16'h3333;
`else
    exp_b = 16'h6666;
`endif
    for (int i = 0; i < 15; i++) send_step(8'h39, pm4(60, 60, 60, 60), 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL auto_ready_before got=%b exp=1", in_ready); end
    send_step(8'h39, pm4(60, 60, 5, 60), 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL auto_ready_after got=%b exp=0", in_ready); end
    collect(16, b, l, got);
    total++; if (got != 16) begin bad++; $display("FAIL auto_count got=%0d exp=16", got); end
    total++; if (b !== exp_b) begin bad++; $display("FAIL auto_bits got=%h exp=%h", b, exp_b); end
    total++; if (l !== 16'h8000) begin bad++; $display("FAIL auto_last got=%h exp=8000", l); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat, exp_b, b;
    logic held_b, held_l, stalled;
    int got;
    pat = 4'b1001;  // out_ready sequence 1,0,0,1 by index
`ifdef ZERO_TERM_EN
    exp_b = 4'b0011;
`else
    exp_b = 4'b1001;
`endif
    for (int i = 0; i < 3; i++) send_step(8'h39, pm4(50, 50, 50, 50), 1'b0);
    send_step(8'h39, pm4(1, 50, 50, 50), 1'b1);
    got = 0; b = '0; stalled = 1'b0; held_b = 1'b0; held_l = 1'b0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      out_ready = pat[c % 4];
      if (out_valid) begin
        if (stalled) begin
          total++;
          if ({out_bit, out_last} !== {held_b, held_l}) begin
            bad++; $display("FAIL bp_hold got=%b exp=%b", {out_bit, out_last}, {held_b, held_l});
          end
        end
        if (out_ready) begin
          b[got] = out_bit; got++; stalled = 1'b0;
        end else begin
          held_b = out_bit; held_l = out_last; stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got); end
    total++; if (b !== exp_b) begin bad++; $display("FAIL bp_bits got=%b exp=%b", b, exp_b); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_extra got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    logic [15:0] b, l; int got; logic exp_b;
`ifdef ZERO_TERM_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    // s0=127 is the largest unsigned metric; s2 is the unique minimum
    send_step(8'h00, pm4(50, 3, 4, 127), 1'b1);
    collect(1, b, l, got);
    total++; if (got != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got); end
    total++; if ({b[0], l[0]} !== {exp_b, 1'b1}) begin bad++; $display("FAIL single_bit_last got=%b exp=%b", {b[0], l[0]}, {exp_b, 1'b1}); end
  endtask

  task automatic test_reset_mid_trace();
    logic [15:0] b, l; int got; logic [3:0] exp_b;
`ifdef ZERO_TERM_EN
    exp_b = 4'b0011;
`else
    exp_b = 4'b1100;
`endif
    for (int i = 0; i < 5; i++) send_step(8'hff, pm4(0, 0, 0, 0), 1'b0);
    send_step(8'hff, pm4(0, 9, 9, 9), 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++; if ({in_ready, busy, out_valid, out_bit, out_last} !== 5'b10000) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=10000", {in_ready, busy, out_valid, out_bit, out_last});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_step(8'h39, pm4(50, 50, 50, 50), 1'b0);
    send_step(8'h39, pm4(50, 2, 50, 50), 1'b1);
    collect(4, b, l, got);
    total++; if (got != 4) begin bad++; $display("FAIL midrst_count got=%0d exp=4", got); end
    total++; if (b[3:0] !== exp_b) begin bad++; $display("FAIL midrst_bits got=%b exp=%b", b[3:0], exp_b); end
    total++; if (l[3:0] !== 4'b1000) begin bad++; $display("FAIL midrst_last got=%b exp=1000", l[3:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_autoclose();
    test_backpressure();
    test_single();
    test_reset_mid_trace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
